// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   - MD_* operation codes carried on md_op
//   - default latencies for multiply-class and divide-class operations
//   - FSM state encoding and the pending-result record
package md_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MADD  = 3'd5;
    localparam logic [2:0] MD_MTHI  = 3'd6;
    localparam logic [2:0] MD_MTLO  = 3'd7;

    localparam int MD_MUL_CYCLES = 5;
    localparam int MD_DIV_CYCLES = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Result computed at launch, held until the commit edge.
    // wr is cleared for divide-by-zero so HI/LO survive the commit.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } md_pend_t;

endpackage

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// Long operations (mult, multu, madd, div, divu) compute their 64-bit result
// at the launch edge into pending registers and commit it to HI/LO after a
// fixed busy window; mthi/mtlo write immediately when idle.
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start, md_op    EX holds an MD instruction this cycle, and which one
//   A, B            forwarded rs / rt operands
//   rd_hi           EX instruction is mfhi (md_out selects HI)
//   id_md_use       ID instruction touches HI/LO
//   busy            long operation in flight
//   md_stall        freeze IF/ID: id_md_use && (busy || long op starting)
//   HI, LO          architectural HI/LO
//   md_out          rd_hi ? HI : LO (combinational)
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MUL_CYCLES = MD_MUL_CYCLES,
    parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    input  logic        id_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    md_pend_t         pend, pend_nxt;
    logic             start_long, is_div, launch, commit, short_ok;

    // Arithmetic operands and results
    logic signed [63:0] a_ext, b_ext, prod_s;
    logic        [63:0] prod_u, madd_sum;
    logic signed [31:0] a_sg, b_sg, quot_s, rem_s;
    logic        [31:0] b_u, quot_u, rem_u;
    logic               div_ovf;

    assign start_long = start && (md_op == MD_MULT || md_op == MD_MULTU ||
                                  md_op == MD_DIV  || md_op == MD_DIVU  ||
                                  md_op == MD_MADD);
    assign is_div     = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign short_ok   = start && (state == ST_IDLE);

    assign busy     = (state == ST_BUSY);
    assign md_stall = id_md_use && (busy || start_long);
    assign md_out   = rd_hi ? HI : LO;

    // Sign-extended operands give the correct low 64 bits of the signed product.
    assign a_ext    = {{32{A[31]}}, A};
    assign b_ext    = {{32{B[31]}}, B};
    assign prod_s   = a_ext * b_ext;
    assign prod_u   = {32'd0, A} * {32'd0, B};
    assign madd_sum = {HI, LO} + prod_s;

    // The single overflowing signed quotient (-2^31 / -1) and a zero divisor
    // are steered to a divisor of 1 so the operator never sees them; their
    // results are overridden or discarded below.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign a_sg    = A;
    assign b_sg    = (B == 32'd0 || div_ovf) ? 32'sd1 : B;
    assign quot_s  = div_ovf ? 32'sh8000_0000 : (a_sg / b_sg);
    assign rem_s   = div_ovf ? 32'sd0 : (a_sg % b_sg);
    assign b_u     = (B == 32'd0) ? 32'd1 : B;
    assign quot_u  = A / b_u;
    assign rem_u   = A % b_u;

    always_comb begin
        pend_nxt = '0;
        case (md_op)
            MD_MULT:  pend_nxt = '{hi: prod_s[63:32],   lo: prod_s[31:0],   wr: 1'b1};
            MD_MULTU: pend_nxt = '{hi: prod_u[63:32],   lo: prod_u[31:0],   wr: 1'b1};
            MD_MADD:  pend_nxt = '{hi: madd_sum[63:32], lo: madd_sum[31:0], wr: 1'b1};
            MD_DIV:   pend_nxt = '{hi: rem_s,  lo: quot_s, wr: (B != 32'd0)};
            MD_DIVU:  pend_nxt = '{hi: rem_u,  lo: quot_u, wr: (B != 32'd0)};
            default:  pend_nxt = '0;
        endcase
    end

    // Next-state: starts are only honoured in IDLE; BUSY counts down to commit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        launch    = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_long) begin
                    launch    = 1'b1;
                    state_nxt = ST_BUSY;
                    cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                end
            end
            ST_BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pend  <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (launch)
                pend <= pend_nxt;
            if (commit) begin
                if (pend.wr) begin
                    HI <= pend.hi;
                    LO <= pend.lo;
                end
            end else if (short_ok && md_op == MD_MTHI) begin
                HI <= A;
            end else if (short_ok && md_op == MD_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It owns the HI/LO registers.
- It executes mult, multu, div, divu, madd, mthi and mtlo, and supplies mfhi/mflo data.
- It is the producer side of HI/LO data consumed by the forwarding network.
- It models fixed multi-cycle latency with a busy counter. It also emits the stall request that the hazard unit uses to freeze IF/ID while a HI/LO-touching instruction waits in ID.

Parameters:
- MUL_CYCLES, 5, busy duration for mult/multu/madd.
- DIV_CYCLES, 10, busy duration for div/divu.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse: EX holds an MD instruction this cycle.
- md_op  input  3  operation code (MD_* constants).
- A  input  32  forwarded rs value in EX.
- B  input  32  forwarded rt value in EX.
- rd_hi  input  1  EX instruction is mfhi (selects HI on md_out).
- id_md_use  input  1  ID instruction is any of mult/multu/div/divu/madd/mthi/mtlo/mfhi/mflo.
- busy  output  1  an operation is in flight.
- md_stall  output  1  request to stall ID: id_md_use && (busy || start_long).
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- md_out  output  32  rd_hi ? HI : LO, combinational.

Behaviour:
- Reset: HI=0, LO=0, busy=0, counter=0, pending results=0, md_stall=0. Reset takes effect immediately, independent of clk.
- Reset mid-operation aborts the operation. HI/LO stay 0 and nothing commits afterward.
- start_long = start && md_op in {MULT, MULTU, DIV, DIVU, MADD}.

Long operation, start sampled high at edge T:
- Compute the full 64-bit result into pending registers at edge T.
- Load counter = MUL_CYCLES or DIV_CYCLES.
- busy is high from after edge T through edge T+N. It falls at edge T+N, and HI/LO take the pending values at that same edge.
- Old HI/LO stay visible on HI/LO/md_out throughout the busy window.
- The counter decrements each edge while busy. Commit happens when the counter transitions 1 to 0.

Arithmetic rules:
- mult: signed 32x32 to 64, {HI,LO}=product.
- multu: unsigned 32x32 to 64, {HI,LO}=product.
- madd: {HI,LO} = {HI,LO} + signed(A)*signed(B), modulo 2^64. Uses the HI/LO values at edge T.
- div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0), div or divu: busy runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.

Short operations:
- mthi: HI=A at the sampling edge, no busy.
- mtlo: LO=A at the sampling edge, no busy.

Other rules:
- start while busy is ignored: no state change, counter unaffected. The hazard unit guarantees this never occurs legally; the bench checks that it is ignored.
- md_op=MD_NONE with start=1 is a no-op.
- md_stall is combinational. It is high when id_md_use=1 and either busy=1 or a long op is starting this cycle.
  - On the commit edge busy drops, so md_stall drops in the following cycle and ID proceeds.
- mfhi/mflo in EX read the committed HI/LO via md_out. There is no bypass of pending results, because the stall makes one unnecessary.

State machine:
- IDLE to BUSY on start_long.
- BUSY to IDLE on counter==1 at an edge (commit).
- BUSY to IDLE on reset.
- mthi/mtlo are legal only in IDLE.

Decomposition:
- Shared package/header (alongside the existing wire definitions) holds:
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MADD=5, MD_MTHI=6, MD_MTLO=7.
  - Default latency constants 5 and 10.
- No sub-module. Counter, pending registers and the arithmetic stay in one module.
- The decode of md_op and id_md_use from IR is done by the existing instruction-decode module at the top level.

Test Plan:
- Signed multiply and stall timing:
  - Reset, then start mult with A=0xFFFFFFFE (-2), B=3 at edge T: busy high T+1..T+5.
  - HI=0 and LO=0 are held until edge T+5, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
  - With id_md_use=1 throughout, md_stall is high from the start cycle until busy falls.
- Signed divide:
  - div with A=-7, B=2: after 10 cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - divu with A=7, B=2: LO=3, HI=1.
- Divide edge cases:
  - div by zero with HI=0x11, LO=0x22 preset via mthi/mtlo: busy lasts 10 cycles, then HI=0x11 and LO=0x22 unchanged.
  - 0x80000000 / -1: LO=0x80000000, HI=0.
- madd:
  - Preset HI=0, LO=0xFFFFFFFF, then madd with A=1, B=1.
  - After 5 cycles, HI=1 and LO=0.
- Ignored start:
  - Issue mult, then at busy cycle 2 issue mthi with A=5 and a second mult.
  - Both are ignored; the commit equals the first mult only, at the original edge.
- Reset mid-operation:
  - Assert reset during cycle 3 of a div. busy=0 and HI=LO=0 immediately.
  - No commit follows; md_out=0 with rd_hi at 0 or 1.
